// File: rtl/image_loader.sv
// Frame loader: valid/ready pixel stream written row-major into the source image buffer.
// Optional checksum verification enabled by IMAGE_LOADER_CHECKSUM_EN.
module image_loader #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOAD_REQ,
  input  logic              ABORT,
  input  logic [DATA_W-1:0] S_DATA,
  input  logic              S_VALID,
  output logic              S_READY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_WREN,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              PROC_START,
`ifdef IMAGE_LOADER_CHECKSUM_EN
  input  logic [15:0]       CHK_EXPECT,
  output logic [15:0]       CHECKSUM,
  output logic              CHK_ERR,
`endif
  output logic [ADDR_W-1:0] PIXEL_COUNT
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    START
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic [15:0]       sum_q, sum_d;
  logic              cerr_q, cerr_d;
  logic              chk_bad;

`ifdef IMAGE_LOADER_CHECKSUM_EN
  assign chk_bad = (sum_q != CHK_EXPECT);
`else
  assign chk_bad = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      sum_q   <= '0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      sum_q   <= sum_d;
      cerr_q  <= cerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    sum_d   = sum_q;
    cerr_d  = cerr_q;
    unique case (state_q)
      IDLE: begin
        if (LOAD_REQ) begin
          state_d = LOAD;
          cnt_d   = '0;
          sum_d   = '0;
          cerr_d  = 1'b0;
        end
      end
      LOAD: begin
        // abort wins over a same-cycle handshake
        if (ABORT) begin
          state_d = IDLE;
        end else if (S_VALID) begin
          wren_d = 1'b1;
          addr_d = cnt_q;
          data_d = S_DATA;
          cnt_d  = cnt_q + ADDR_W'(1);
          sum_d  = sum_q + 16'(S_DATA);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = START;
        cerr_d  = cerr_q | chk_bad;
      end
      START: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign S_READY     = (state_q == LOAD);
  assign BUSY        = (state_q != IDLE);
  assign FRAME_DONE  = (state_q == DONE);
  assign PROC_START  = (state_q == START) & ~cerr_q;
  assign MEM_ADDR    = addr_q;
  assign MEM_DATA    = data_q;
  assign MEM_WREN    = wren_q;
  assign PIXEL_COUNT = cnt_q;

`ifdef IMAGE_LOADER_CHECKSUM_EN
  assign CHECKSUM = sum_q;
  assign CHK_ERR  = cerr_q;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: frame-level model plus directed checks.
// Define IMAGE_LOADER_CHECKSUM_EN to exercise the checksum ports.
module tb_image_loader;

  localparam int NPIX = 160 * 120;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        LOAD_REQ = 1'b0;
  logic        ABORT = 1'b0;
  logic [7:0]  S_DATA = '0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [14:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        MEM_WREN;
  logic        BUSY;
  logic        FRAME_DONE;
  logic        PROC_START;
  logic [14:0] PIXEL_COUNT;
`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [15:0] CHK_EXPECT = 16'h4B00;
  logic [15:0] CHECKSUM;
  logic        CHK_ERR;
`endif

  image_loader dut (
    .CLK(CLK),
    .RESET(RESET),
    .LOAD_REQ(LOAD_REQ),
    .ABORT(ABORT),
    .S_DATA(S_DATA),
    .S_VALID(S_VALID),
    .S_READY(S_READY),
    .MEM_ADDR(MEM_ADDR),
    .MEM_DATA(MEM_DATA),
    .MEM_WREN(MEM_WREN),
    .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE),
    .PROC_START(PROC_START),
`ifdef IMAGE_LOADER_CHECKSUM_EN
    .CHK_EXPECT(CHK_EXPECT),
    .CHECKSUM(CHECKSUM),
    .CHK_ERR(CHK_ERR),
`endif
    .PIXEL_COUNT(PIXEL_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int a);
`ifdef IMAGE_LOADER_CHECKSUM_EN
    return 8'h01;
`else
    return 8'(a);
`endif
  endfunction

  // Frame-level model: loading flag, pixels taken, cycles since frame end
  bit  m_ld;
  int  m_cnt;
  int  m_age;
  bit  m_wr;
  int  m_addr;
  int  m_data;
  int  m_sum;
  bit  m_cerr;
  wire m_acc = m_ld & S_VALID & ~ABORT;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_ld <= 0; m_cnt <= 0; m_age <= 0; m_wr <= 0;
      m_addr <= 0; m_data <= 0; m_sum <= 0; m_cerr <= 0;
    end else begin
      m_wr <= m_acc;
      if (m_acc) begin
        m_addr <= m_cnt;
        m_data <= int'(S_DATA);
        m_cnt  <= m_cnt + 1;
        m_sum  <= (m_sum + int'(S_DATA)) % 65536;
      end
      if (m_acc && m_cnt == NPIX - 1) begin
        m_ld <= 0;
        m_age <= 1;
      end else if (m_ld && ABORT) begin
        m_ld <= 0;
      end
      if (m_age == 1) begin
        m_age <= 2;
`ifdef IMAGE_LOADER_CHECKSUM_EN
        if (m_sum != int'(CHK_EXPECT)) m_cerr <= 1;
`endif
      end else if (m_age == 2) begin
        m_age <= 0;
      end
      if (!m_ld && m_age == 0 && LOAD_REQ) begin
        m_ld <= 1; m_cnt <= 0; m_sum <= 0; m_cerr <= 0;
      end
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_wr = 0;
  int n_fd = 0;
  int n_ps = 0;
  int fd_edge = -1;
  int ps_edge = -1;
  logic [7:0] mem [NPIX];

  always @(negedge CLK) begin
    chk("s_ready", int'(S_READY), int'(m_ld));
    chk("mem_wren", int'(MEM_WREN), int'(m_wr));
    chk("mem_addr", int'(MEM_ADDR), m_addr);
    chk("mem_data", int'(MEM_DATA), m_data);
    chk("busy", int'(BUSY), int'(m_ld || m_age != 0));
    chk("frame_done", int'(FRAME_DONE), int'(m_age == 1));
    chk("proc_start", int'(PROC_START), int'(m_age == 2 && !m_cerr));
    chk("pixel_count", int'(PIXEL_COUNT), m_cnt);
`ifdef IMAGE_LOADER_CHECKSUM_EN
    chk("checksum", int'(CHECKSUM), m_sum);
    chk("chk_err", int'(CHK_ERR), int'(m_cerr));
`endif
    if (MEM_WREN) begin
      n_wr++;
      if (int'(MEM_ADDR) < NPIX) mem[MEM_ADDR] = MEM_DATA;
    end
    if (FRAME_DONE) begin n_fd++; fd_edge = cyc; end
    if (PROC_START) begin n_ps++; ps_edge = cyc; end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int last_hs = -1;

  task automatic send(input int n, input bit gaps);
    int sent = 0;
    int t = 0;
    bit hs;
    while (sent < n && t < 4 * n + 100) begin
      S_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      S_DATA = pix(sent);
      hs = S_VALID & S_READY;
      tick();
      if (hs) begin sent++; last_hs = cyc; end
      t++;
    end
    S_VALID = 1'b0;
    if (sent < n) chk("send_timeout", sent, n);
  endtask

  task automatic start_load();
    LOAD_REQ = 1'b1;
    tick();
    LOAD_REQ = 1'b0;
  endtask

  task automatic tail(input int k);
    for (int i = 0; i < k; i++) begin
      S_VALID = 1'b1;
      S_DATA = 8'hAA;
      tick();
    end
    S_VALID = 1'b0;
  endtask

  int w0, f0, p0;

  initial begin
    #23;
    chk("rst_ready", int'(S_READY), 0);
    chk("rst_wren", int'(MEM_WREN), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_pc", int'(PIXEL_COUNT), 0);
    RESET = 1'b1;
    tick();

    // Frame 1: continuous stream
    w0 = n_wr; f0 = n_fd; p0 = n_ps;
    start_load();
    send(NPIX, 1'b0);
    tail(6);
    chk("f1_writes", n_wr - w0, 19200);
    chk("f1_pc", int'(PIXEL_COUNT), 19200);
    chk("f1_fd_cnt", n_fd - f0, 1);
    chk("f1_ps_cnt", n_ps - p0, 1);
    chk("f1_fd_lat", fd_edge - last_hs, 0);
    chk("f1_ps_lat", ps_edge - last_hs, 1);
    chk("f1_ready", int'(S_READY), 0);
    chk("f1_mem0", int'(mem[0]), int'(pix(0)));
    chk("f1_memlast", int'(mem[NPIX-1]), int'(pix(19199)));
`ifdef IMAGE_LOADER_CHECKSUM_EN
    chk("f1_sum", int'(CHECKSUM), 16'h4B00);
    chk("f1_cerr", int'(CHK_ERR), 0);
    CHK_EXPECT = 16'h4AFF;
`else
    chk("f1_memlast_lit", int'(mem[NPIX-1]), 8'hFF);
    chk("f1_mem300", int'(mem[300]), 8'h2C);
`endif

    // Frame 2: ~50% valid gaps, extra bytes offered afterwards
    w0 = n_wr; f0 = n_fd; p0 = n_ps;
    start_load();
    send(NPIX, 1'b1);
    tail(8);
    chk("f2_writes", n_wr - w0, 19200);
    chk("f2_pc", int'(PIXEL_COUNT), 19200);
    chk("f2_fd_cnt", n_fd - f0, 1);
`ifdef IMAGE_LOADER_CHECKSUM_EN
    chk("f2_ps_cnt", n_ps - p0, 0);
    chk("f2_cerr", int'(CHK_ERR), 1);
`else
    chk("f2_ps_cnt", n_ps - p0, 1);
`endif

    // Abort after 100 pixels with a same-cycle handshake
    w0 = n_wr; f0 = n_fd; p0 = n_ps;
    start_load();
`ifdef IMAGE_LOADER_CHECKSUM_EN
    chk("ab_cerr_clr", int'(CHK_ERR), 0);
`endif
    send(100, 1'b0);
    S_VALID = 1'b1;
    ABORT = 1'b1;
    S_DATA = pix(100);
    tick();
    ABORT = 1'b0;
    S_VALID = 1'b0;
    tick();
    tick();
    chk("ab_writes", n_wr - w0, 100);
    chk("ab_pc", int'(PIXEL_COUNT), 100);
    chk("ab_busy", int'(BUSY), 0);
    chk("ab_fd", n_fd - f0, 0);
    chk("ab_ps", n_ps - p0, 0);

    // Restart with LOAD_REQ held high during the load
    w0 = n_wr;
    LOAD_REQ = 1'b1;
    tick();
    send(50, 1'b0);
    chk("lr_pc", int'(PIXEL_COUNT), 50);
    chk("lr_addr", int'(MEM_ADDR), 49);

    // Asynchronous reset between edges while writing
    S_VALID = 1'b1;
    S_DATA = pix(50);
    #2;
    RESET = 1'b0;
    #1;
    chk("ar_ready", int'(S_READY), 0);
    chk("ar_wren", int'(MEM_WREN), 0);
    chk("ar_busy", int'(BUSY), 0);
    chk("ar_pc", int'(PIXEL_COUNT), 0);
    LOAD_REQ = 1'b0;
    S_VALID = 1'b0;
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", int'(BUSY), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
